// File: rtl/a0_trace_fifo.sv
// Captures every change of the core's a0 register into a small FIFO drained over valid/ready.
// Optional per-entry cycle timestamp when A0_TRACE_TS_EN is defined; out_ts is 0 otherwise.
module a0_trace_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           a0_in,
  input  logic                       sample_en,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] prev;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic [WIDTH-1:0] data_mem [DEPTH];

  logic change;
  logic pop;
  logic push;
  logic empty;

  // Handshake: out_valid is high exactly when the FIFO holds an entry; an entry
  // transfers on a rising edge where out_valid && out_ready, unless clear is high.
  assign empty  = (cnt == '0);
  assign change = sample_en && (a0_in != prev);
  assign pop    = !empty && out_ready;
  // A full FIFO still accepts a change when the head leaves in the same cycle.
  assign push   = change && ((cnt != CW'(DEPTH)) || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (clear) begin
      prev   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (change) prev <= a0_in;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (change && !push) ovf <= 1'b1;
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push && !clear) data_mem[wr_ptr] <= a0_in;
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : data_mem[rd_ptr];
  assign count     = cnt;
  assign overflow  = ovf;

`ifdef A0_TRACE_TS_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts_cnt <= '0;
    end else if (clear) begin
      ts_cnt <= '0;
    end else if (sample_en) begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) ts_mem[wr_ptr] <= ts_cnt;
  end

  assign out_ts = empty ? '0 : ts_mem[rd_ptr];
`else
  assign out_ts = '0;
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Bench for a0_trace_fifo: directed scenarios plus random traffic against a queue-based model.
// Timestamp expectations follow A0_TRACE_TS_EN.
module tb_a0_trace_fifo;
  localparam int W   = 32;
  localparam int D   = 8;
  localparam int TSW = 4;
  localparam int CW  = $clog2(D) + 1;
`ifdef A0_TRACE_TS_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic [W-1:0]   a0_in;
  logic           sample_en;
  logic           clear;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [TSW-1:0] out_ts;
  logic [CW-1:0]  count;
  logic           overflow;

  a0_trace_fifo #(.WIDTH(W), .DEPTH(D), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst), .a0_in(a0_in), .sample_en(sample_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ts(out_ts), .count(count), .overflow(overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state and scoreboard
  logic [W+TSW-1:0] exp_q[$];
  int               mdl_cnt;
  bit               mdl_ovf;
  logic [W-1:0]     mdl_prev;
  logic [TSW-1:0]   mdl_ts;
  int               cur_cnt;
  bit               cur_ovf;
  bit               mon_en;
  int               n_vec;
  int               n_chk;
  int               n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    mdl_cnt  = 0;
    mdl_ovf  = 1'b0;
    mdl_prev = '0;
    mdl_ts   = '0;
  endtask

  // driver: apply one cycle of inputs and advance the model for the coming edge
  task automatic cycle(input logic [W-1:0] a, input logic se, input logic clr, input logic rdy);
    bit do_pop;
    bit chg;
    @(negedge clk);
    a0_in = a; sample_en = se; clear = clr; out_ready = rdy;
    cur_cnt = mdl_cnt;
    cur_ovf = mdl_ovf;
    mon_en  = 1'b1;
    n_vec++;
    if (clr) begin
      model_clear();
    end else begin
      do_pop = (mdl_cnt > 0) && rdy;
      chg    = se && (a != mdl_prev);
      if (chg) begin
        mdl_prev = a;
        if (mdl_cnt < D || do_pop) begin
          exp_q.push_back({a, TS_ON ? mdl_ts : TSW'(0)});
          mdl_cnt++;
        end else begin
          mdl_ovf = 1'b1;
        end
      end
      if (do_pop) mdl_cnt--;
      if (se) mdl_ts = mdl_ts + 1'b1;
    end
  endtask

  task automatic sync_reset();
    @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b0;
    a0_in = '0; sample_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // reset asserted between edges must empty the FIFO before the next edge
  task automatic async_reset();
    @(negedge clk);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_count", count, 0);
    chk("async_valid", out_valid, 0);
    chk("async_data", out_data, 0);
    a0_in = '0; sample_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // monitor: status checks every cycle, pop-and-compare on each transfer
  always @(negedge clk) begin
    logic [W+TSW-1:0] e;
    #3;
    if (mon_en) begin
      chk("count", count, cur_cnt);
      chk("valid", out_valid, cur_cnt != 0);
      chk("overflow", overflow, cur_ovf);
      if (cur_cnt == 0) begin
        chk("data_empty", out_data, 0);
        chk("ts_empty", out_ts, 0);
      end else if (out_valid && out_ready && !clear) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pop_underflow: transfer seen with scoreboard empty at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e[W+TSW-1:TSW]);
          chk("ts", out_ts, e[TSW-1:0]);
        end
      end
    end
  end

  initial begin
    n_vec = 0; n_chk = 0; n_fail = 0; mon_en = 1'b0;
    cur_cnt = 0; cur_ovf = 1'b0;
    rst = 1'b0;
    a0_in = '0; sample_en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    model_clear();
    sync_reset();

    // a0 held at zero: nothing captured
    repeat (10) cycle(0, 1, 0, 0);

    // repeats collapse to two entries, timestamps 0 and 2
    sync_reset();
    cycle(5, 1, 0, 0); cycle(5, 1, 0, 0);
    cycle(9, 1, 0, 0); cycle(9, 1, 0, 0); cycle(9, 1, 0, 0);
    repeat (3) cycle(9, 1, 0, 1);

    // overflow on 9 and 10, drain 1..8, then 11 is still seen as a change
    for (int v = 1; v <= 10; v++) cycle(W'(v), 1, 0, 0);
    repeat (D) cycle(10, 1, 0, 1);
    cycle(11, 1, 0, 0);
    cycle(11, 1, 0, 1);

    // full with simultaneous pop and push
    for (int v = 20; v < 28; v++) cycle(W'(v), 1, 0, 0);
    cycle(32'hAB, 1, 0, 1);
    repeat (D) cycle(32'hAB, 1, 0, 1);

    // clear beats a same-cycle pop and change
    for (int v = 30; v <= 38; v++) cycle(W'(v), 1, 0, 0);
    repeat (5) cycle(38, 1, 0, 1);
    cycle(50, 1, 1, 1);
    cycle(50, 1, 0, 0);
    cycle(50, 1, 0, 1);

    // asynchronous reset with four entries held, then fresh capture at ts 0
    for (int v = 60; v < 64; v++) cycle(W'(v), 1, 0, 0);
    async_reset();
    cycle(7, 1, 0, 0);
    cycle(7, 1, 0, 1);

    // random traffic, small value range so repeats and drops are frequent
    for (int i = 0; i < 500; i++) begin
      cycle(W'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0);
    end
    repeat (D + 1) cycle(0, 0, 0, 1);

    #5;
    mon_en = 1'b0;
    chk("final_drain", exp_q.size(), 0);
    chk("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
